// File: rtl/prefetch_unit_pkg.sv
// Shared core types for the fetch front end.
// Word, Exception, IdSignals (decode bundle) and FetchState.
package prefetch_unit_pkg;

    typedef logic [31:0] Word;

    typedef enum logic [1:0] {
        EXCEPT_NONE        = 2'd0,
        EXCEPT_BUS_FAULT   = 2'd1,
        EXCEPT_USAGE_FAULT = 2'd2
    } Exception;

    typedef struct packed {
        Exception exception;
        Word      instruction;
        Word      programCounter;
        Word      linkAddress;
    } IdSignals;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } FetchState;

    localparam Word WORD_BYTES = 32'd4;

    function automatic Word next_word(input Word a);
        return a + WORD_BYTES;
    endfunction

endpackage

// File: rtl/prefetch_unit_if.sv
// Fetch bus, redirect and decode handshake bundle.
// master: prefetch side (drives memReq*, id*); slave: memory/decode side.
interface prefetch_unit_if
    import prefetch_unit_pkg::*;
();
    logic     memReqValid;
    Word      memReqAddr;
    logic     memReqReady;
    logic     memRspValid;
    Word      memRspData;
    logic     memRspFault;
    logic     jumpEnable;
    Word      jumpAddress;
    logic     idReady;
    logic     idValid;
    IdSignals idSignals;

    modport master (
        output memReqValid, memReqAddr,
        output idValid, idSignals,
        input  memReqReady,
        input  memRspValid, memRspData, memRspFault,
        input  jumpEnable, jumpAddress,
        input  idReady
    );

    modport slave (
        input  memReqValid, memReqAddr,
        input  idValid, idSignals,
        output memReqReady,
        output memRspValid, memRspData, memRspFault,
        output jumpEnable, jumpAddress,
        output idReady
    );
endinterface

// File: rtl/prefetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of decode bundles with flush.
// Ports: push/pop/flush, push_data, head, full, empty, count.
module fetch_queue
    import prefetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  IdSignals               push_data,
    output IdSignals               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    IdSignals       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_slot;
    logic           do_push;
    logic           do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty && !flush;
    // A flush empties the queue first, so a push alongside it
    // always lands in slot 0.
    assign do_push = push && (flush || !full || do_pop);
    assign wr_slot = flush ? '0 : wr_ptr;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(do_push);
            count  <= CW'(do_push);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_slot] <= push_data;
    end
endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch: issues word fetches, queues responses for decode.
// Ports: clk, reset, bus (prefetch_unit_if.master).
// Optional PREFETCH_PERF_COUNT_EN adds stallCycles, flushCount.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int  DEPTH        = 4,
    parameter Word RESET_VECTOR = 32'h0
) (
    input logic             clk,
    input logic             reset,
    prefetch_unit_if.master bus
`ifdef PREFETCH_PERF_COUNT_EN
    ,
    output logic [31:0]     stallCycles,
    output logic [31:0]     flushCount
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    FetchState     state;
    Word           fetch_pc;
    Word           rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] out_next;
    logic [CW-1:0] q_count;
    logic [CW:0]   in_use;

    logic     q_push;
    logic     q_pop;
    logic     q_flush;
    logic     q_full;
    logic     q_empty;
    IdSignals q_data;
    IdSignals q_head;

    logic req_valid;
    logic req_fire;
    logic rsp;
    logic jump;
    logic aligned;
    logic discarding;

    // In-flight requests reserve queue slots so a response
    // always finds room.
    assign in_use     = {1'b0, q_count} + {1'b0, outstanding};
    assign req_valid  = !reset && state == FETCH
                      && in_use < (CW+1)'(DEPTH);
    assign req_fire   = req_valid && bus.memReqReady;
    assign rsp        = bus.memRspValid;
    assign jump       = bus.jumpEnable;
    assign aligned    = bus.jumpAddress[1:0] == 2'b00;
    assign discarding = discard_cnt != '0;
    assign out_next   = outstanding + CW'(req_fire) - CW'(rsp);

    always_comb begin
        q_flush = jump;
        q_pop   = !q_empty && bus.idReady && !jump;
        q_push  = 1'b0;
        q_data  = '{
            exception:      bus.memRspFault ? EXCEPT_BUS_FAULT
                                            : EXCEPT_NONE,
            instruction:    bus.memRspData,
            programCounter: rsp_pc,
            linkAddress:    next_word(rsp_pc)
        };
        if (jump) begin
            q_push = !aligned;
            q_data = '{
                exception:      EXCEPT_USAGE_FAULT,
                instruction:    '0,
                programCounter: bus.jumpAddress,
                linkAddress:    next_word(bus.jumpAddress)
            };
        end else if (rsp) begin
            q_push = !discarding && (!q_full || q_pop);
        end
    end

    // rsp_pc tracks the PC of the next kept response; responses
    // are in order, so no per-request tag storage is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_VECTOR;
            rsp_pc      <= RESET_VECTOR;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            outstanding <= out_next;
            if (jump) begin
                fetch_pc    <= bus.jumpAddress;
                rsp_pc      <= bus.jumpAddress;
                discard_cnt <= out_next;
                state       <= aligned ? FETCH : HALT;
            end else begin
                if (req_fire)
                    fetch_pc <= next_word(fetch_pc);
                if (rsp && discarding)
                    discard_cnt <= discard_cnt - CW'(1);
                if (rsp && !discarding)
                    rsp_pc <= next_word(rsp_pc);
                if (q_push && bus.memRspFault)
                    state <= HALT;
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (q_flush),
        .push_data (q_data),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign bus.memReqValid = req_valid;
    assign bus.memReqAddr  = fetch_pc;
    assign bus.idValid     = !q_empty;
    assign bus.idSignals   = q_empty ? '0 : q_head;

`ifdef PREFETCH_PERF_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (q_empty && state == FETCH && stallCycles != '1)
                stallCycles <= stallCycles + 32'd1;
            if (jump && flushCount != '1)
                flushCount <= flushCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit.
// Request-level reference model with in-order memory responder.
module tb_prefetch_unit;
    import prefetch_unit_pkg::*;

    localparam int  DEPTH = 4;
    localparam Word RV    = 32'h0;

    typedef struct {
        Word addr;
        bit  discard;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    prefetch_unit_if bus();

`ifdef PREFETCH_PERF_COUNT_EN
    logic [31:0] stallCycles;
    logic [31:0] flushCount;
`endif

    prefetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PREFETCH_PERF_COUNT_EN
        ,
        .stallCycles (stallCycles),
        .flushCount  (flushCount)
`endif
    );

    always #5 clk = ~clk;

    int       vectors;
    int       miscompares;
    req_t     inflight[$];
    IdSignals expq[$];
    Word      m_pc;
    bit       m_halt;
    bit       fault_en;
    Word      fault_addr;
    int       stall_exp;
    int       flush_exp;

    function automatic Word data_of(input Word a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic bit exp_req_valid();
        return !m_halt && (expq.size() + inflight.size() < DEPTH);
    endfunction

    function automatic IdSignals exp_head();
        if (expq.size() == 0) return '0;
        return expq[0];
    endfunction

    task automatic drive_idle();
        bus.memReqReady = 1'b0;
        bus.memRspValid = 1'b0;
        bus.memRspData  = '0;
        bus.memRspFault = 1'b0;
        bus.jumpEnable  = 1'b0;
        bus.jumpAddress = '0;
        bus.idReady     = 1'b0;
    endtask

    task automatic model_clear();
        inflight.delete();
        expq.delete();
        m_pc      = RV;
        m_halt    = 1'b0;
        stall_exp = 0;
        flush_exp = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        model_clear();
        reset = 1'b0;
        #1;
    endtask

    // One clock: drive inputs, advance the model, land on next negedge.
    task automatic cycle(input bit ready, input bit rsp_en,
                         input bit jump, input Word jaddr,
                         input bit idr);
        bit       fire;
        bit       rsp;
        bit       pop;
        bit       flt;
        req_t     r;
        IdSignals e;
        logic [1:0] low;
        fire = exp_req_valid() && ready;
        rsp  = rsp_en && inflight.size() != 0;
        pop  = expq.size() != 0 && idr;
        flt  = 1'b0;
        r    = '{32'h0, 1'b0};
        if (expq.size() == 0 && !m_halt) stall_exp++;
        drive_idle();
        bus.memReqReady = ready;
        bus.memRspValid = rsp;
        if (rsp) begin
            r = inflight.pop_front();
            flt = fault_en && r.addr == fault_addr;
            bus.memRspData  = data_of(r.addr);
            bus.memRspFault = flt;
        end
        bus.jumpEnable  = jump;
        bus.jumpAddress = jaddr;
        bus.idReady     = idr;
        low = jaddr[1:0];
        if (jump) begin
            flush_exp++;
            if (fire) inflight.push_back('{m_pc, 1'b1});
            foreach (inflight[i]) inflight[i].discard = 1'b1;
            expq.delete();
            m_pc   = jaddr;
            m_halt = low != 2'b00;
            if (m_halt) begin
                e.exception      = EXCEPT_USAGE_FAULT;
                e.instruction    = '0;
                e.programCounter = jaddr;
                e.linkAddress    = jaddr + 32'd4;
                expq.push_back(e);
            end
        end else begin
            if (fire) begin
                inflight.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (pop) void'(expq.pop_front());
            if (rsp && !r.discard) begin
                e.exception      = flt ? EXCEPT_BUS_FAULT : EXCEPT_NONE;
                e.instruction    = data_of(r.addr);
                e.programCounter = r.addr;
                e.linkAddress    = r.addr + 32'd4;
                expq.push_back(e);
                if (flt) m_halt = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.memReqValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.req_valid got %b exp 0", bus.memReqValid);
        end
        vectors++;
        if (bus.idValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset.id_valid got %b exp 0", bus.idValid);
        end
        vectors++;
        if (bus.idSignals !== '0) begin
            miscompares++;
            $display("FAIL reset.id_signals got %h exp 0", bus.idSignals);
        end
        model_clear();
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== RV) begin
            miscompares++;
            $display("FAIL reset.first_req got %b/%h exp 1/%h",
                     bus.memReqValid, bus.memReqAddr, RV);
        end
    endtask

    task automatic test_basic_fetch();
        Word want;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            want = Word'(k) * 32'd4;
            vectors++;
            if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== want) begin
                miscompares++;
                $display("FAIL basic.req k=%0d got %b/%h exp 1/%h",
                         k, bus.memReqValid, bus.memReqAddr, want);
            end
            vectors++;
            if (bus.idValid !== (k >= 2)) begin
                miscompares++;
                $display("FAIL basic.latency k=%0d got %b exp %b",
                         k, bus.idValid, k >= 2);
            end
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        vectors++;
        if (bus.idSignals.programCounter !== 32'h0
            || bus.idSignals.linkAddress !== 32'h4
            || bus.idSignals.instruction !== data_of(32'h0)
            || bus.idSignals.exception !== EXCEPT_NONE) begin
            miscompares++;
            $display("FAIL basic.head got %h exp pc 0 link 4",
                     bus.idSignals);
        end
    endtask

    task automatic test_backpressure();
        int issued;
        apply_reset();
        issued = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.memReqValid === 1'b1) issued++;
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        vectors++;
        if (issued !== 4) begin
            miscompares++;
            $display("FAIL backpressure.issued got %0d exp 4", issued);
        end
        vectors++;
        if (bus.memReqValid !== 1'b0
            || bus.idSignals.programCounter !== 32'h0) begin
            miscompares++;
            $display("FAIL backpressure.full got %b/%h exp 0/0",
                     bus.memReqValid, bus.idSignals.programCounter);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== 32'h10
            || bus.idSignals.programCounter !== 32'h4) begin
            miscompares++;
            $display("FAIL backpressure.pop got %b/%h/%h exp 1/10/4",
                     bus.memReqValid, bus.memReqAddr,
                     bus.idSignals.programCounter);
        end
    endtask

    task automatic test_jump_aligned();
        apply_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        vectors++;
        if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== 32'h100
            || bus.idValid !== 1'b0) begin
            miscompares++;
            $display("FAIL jump.redirect got %b/%h/%b exp 1/100/0",
                     bus.memReqValid, bus.memReqAddr, bus.idValid);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (bus.idValid !== (expq.size() != 0)
                || bus.idSignals !== exp_head()) begin
                miscompares++;
                $display("FAIL jump.discard k=%0d got %b/%h exp %b/%h",
                         k, bus.idValid, bus.idSignals,
                         expq.size() != 0, exp_head());
            end
        end
        vectors++;
        if (bus.idSignals.programCounter !== 32'h100
            || bus.idSignals.instruction !== data_of(32'h100)) begin
            miscompares++;
            $display("FAIL jump.head got %h exp pc 100",
                     bus.idSignals);
        end
    endtask

    task automatic test_jump_misaligned();
        apply_reset();
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h102, 1'b0);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (bus.memReqValid !== 1'b0 || bus.idValid !== 1'b1
                || bus.idSignals.exception !== EXCEPT_USAGE_FAULT
                || bus.idSignals.programCounter !== 32'h102
                || bus.idSignals.instruction !== 32'h0) begin
                miscompares++;
                $display("FAIL misalign.entry k=%0d got %b/%b/%h",
                         k, bus.memReqValid, bus.idValid,
                         bus.idSignals);
            end
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (bus.idValid !== 1'b0 || bus.memReqValid !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign.single got %b/%b exp 0/0",
                     bus.idValid, bus.memReqValid);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        vectors++;
        if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== 32'h200) begin
            miscompares++;
            $display("FAIL misalign.resume got %b/%h exp 1/200",
                     bus.memReqValid, bus.memReqAddr);
        end
    endtask

    task automatic test_bus_fault();
        apply_reset();
        fault_en   = 1'b1;
        fault_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (bus.memReqValid !== exp_req_valid()) begin
                miscompares++;
                $display("FAIL fault.req_valid k=%0d got %b exp %b",
                         k, bus.memReqValid, exp_req_valid());
            end
        end
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (bus.memReqValid !== 1'b0
            || bus.idSignals.exception !== EXCEPT_BUS_FAULT
            || bus.idSignals.programCounter !== 32'h8) begin
            miscompares++;
            $display("FAIL fault.entry got %b/%h exp 0/bus fault pc 8",
                     bus.memReqValid, bus.idSignals);
        end
        fault_en = 1'b0;
    endtask

`ifdef PREFETCH_PERF_COUNT_EN
    task automatic test_perf();
        apply_reset();
        vectors++;
        if (stallCycles !== 32'd0 || flushCount !== 32'd0) begin
            miscompares++;
            $display("FAIL perf.reset got %0d/%0d exp 0/0",
                     stallCycles, flushCount);
        end
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (stallCycles !== 32'd5) begin
            miscompares++;
            $display("FAIL perf.stall got %0d exp 5", stallCycles);
        end
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        vectors++;
        if (flushCount !== 32'd3
            || stallCycles !== 32'(stall_exp)) begin
            miscompares++;
            $display("FAIL perf.flush got %0d/%0d exp 3/%0d",
                     flushCount, stallCycles, stall_exp);
        end
    endtask
`endif

    task automatic test_random();
        bit  j;
        Word ja;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) apply_reset();
            j  = $urandom_range(0, 24) == 0;
            ja = Word'($urandom_range(0, 1023)) * 32'd4;
            if ($urandom_range(0, 3) == 0)
                ja = ja + Word'($urandom_range(1, 3));
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 6,
                  j, ja,
                  $urandom_range(0, 1) == 1);
            vectors++;
            if (bus.memReqValid !== exp_req_valid()) begin
                miscompares++;
                $display("FAIL rand.req_valid n=%0d got %b exp %b",
                         n, bus.memReqValid, exp_req_valid());
            end
            if (exp_req_valid()) begin
                vectors++;
                if (bus.memReqAddr !== m_pc) begin
                    miscompares++;
                    $display("FAIL rand.req_addr n=%0d got %h exp %h",
                             n, bus.memReqAddr, m_pc);
                end
            end
            vectors++;
            if (bus.idValid !== (expq.size() != 0)) begin
                miscompares++;
                $display("FAIL rand.id_valid n=%0d got %b exp %b",
                         n, bus.idValid, expq.size() != 0);
            end
            vectors++;
            if (bus.idSignals !== exp_head()) begin
                miscompares++;
                $display("FAIL rand.id_signals n=%0d got %h exp %h",
                         n, bus.idSignals, exp_head());
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        fault_en    = 1'b0;
        fault_addr  = '0;
        drive_idle();
        model_clear();
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_jump_aligned();
        test_jump_misaligned();
        test_bus_fault();
`ifdef PREFETCH_PERF_COUNT_EN
        test_perf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0, first fetch address (word aligned).
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 memReqValid  out  1  fetch request valid.
REQ-006 memReqAddr  out  32  fetch address (Word).
REQ-007 memReqReady  in  1  memory accepts request.
REQ-008 memRspValid  in  1  in-order response valid; responses are never back-pressured.
REQ-009 memRspData  in  32  instruction word.
REQ-010 memRspFault  in  1  bus fault on this response.
REQ-011 jumpEnable  in  1  redirect request.
REQ-012 jumpAddress  in  32  redirect target.
REQ-013 idReady  in  1  decode stage accepts entry.
REQ-014 idValid  out  1  queue head valid.
REQ-015 idSignals  out  IdSignals  head {exception, instruction, programCounter, linkAddress}.

Function
REQ-016 SHALL issue a request (fetchPc advances by 4) when memReqValid && memReqReady; memReqValid = state==FETCH && (occupancy + outstanding) < DEPTH.
REQ-017 SHALL push each non-discarded response into the queue tagged with its request PC; linkAddress = PC+4 (mod 2^32).
REQ-018 SHALL pop the head when idValid && idReady; simultaneous push and pop on a full queue SHALL be legal.
REQ-019 Queue pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.
REQ-020 Exception field SHALL be EXCEPT_BUS_FAULT when memRspFault, else EXCEPT_NONE.
REQ-021 FSM states: FETCH, HALT. FETCH->HALT when a faulting response is pushed; HALT->FETCH only on an aligned jump.
REQ-022 On jumpEnable with jumpAddress[1:0]==0: next cycle queue empty, fetchPc=jumpAddress, discardCount=outstanding (including any request accepted this cycle), state FETCH.
REQ-023 On jumpEnable with misaligned target: queue flushed, discardCount set as in REQ-022, one entry {EXCEPT_USAGE_FAULT, instruction 0, programCounter=jumpAddress} pushed, state HALT.
REQ-024 While discardCount>0, each memRspValid SHALL decrement discardCount and not push.
REQ-025 Jump SHALL take priority over push and pop in the same cycle; a popped-and-flushed head is consumed.
REQ-026 Fetch-to-idValid latency SHALL be one cycle after memRspValid.

Reset
REQ-027 On reset: fetchPc=RESET_VECTOR, queue empty, outstanding=0, discardCount=0, state FETCH, memReqValid=0, idValid=0, idSignals all zero.
REQ-028 Reset mid-operation SHALL drop all in-flight responses without pushing; responses arriving after reset deasserts are not expected.

Configuration
REQ-029 Macro PREFETCH_PERF_COUNT_EN: when defined, adds outputs stallCycles (32) and flushCount (32), counting cycles with idValid==0 && state==FETCH and accepted jumps, saturating at 32'hFFFF_FFFF, cleared by reset; when undefined, ports and logic absent.

Structure
REQ-030 IdSignals, Exception, Word and EXCEPT_* SHALL come from the shared core package; add FetchState enum there.
REQ-031 Queue SHALL be a sub-module fetch_queue (parameter DEPTH, push/pop/flush, full/empty, count).

Verification
REQ-032 Reset, memReqReady=1, 1-cycle memory: fetches 0x0,0x4,0x8; idSignals.programCounter=0x0, linkAddress=0x4.
REQ-033 idReady=0, DEPTH=4: exactly 4 requests issued, then memReqValid=0 until a pop.
REQ-034 Jump to 0x100 with 2 outstanding: two responses discarded; next idSignals.programCounter=0x100.
REQ-035 Jump to 0x102: single USAGE_FAULT entry pc=0x102, memReqValid=0 until jump to 0x200.
REQ-036 memRspFault on pc=0x8: entry EXCEPT_BUS_FAULT, state HALT, no further requests.
REQ-037 With PREFETCH_PERF_COUNT_EN: 3 jumps -> flushCount=3; 5 empty cycles -> stallCycles=5.
